// File: rtl/ghazi_loader_pkg.sv
// Shared types and constants for the UART program loader.
package ghazi_loader_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} loader_state_e;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

    localparam logic [31:0] TERM_WORD_DEF = 32'h0000_0FFF;
    localparam int          DATA_BITS     = 8;

endpackage

// File: rtl/uart_prog_loader_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, one-cycle byte/error strobes.
module uart_rx
    import ghazi_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 347
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 rx_i,
    output logic                 byte_valid_o,
    output logic [DATA_BITS-1:0] byte_o,
    output logic                 frame_err_o
);

    localparam int             TW       = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0]  FULL_M1  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0]  HALF_M1  = TW'(CLKS_PER_BIT / 2 - 1);
    localparam int             BW       = $clog2(DATA_BITS);
    localparam logic [BW-1:0]  LAST_BIT = BW'(DATA_BITS - 1);

    // [1] is the synchronized line, [2] its previous value for edge detection
    logic [2:0]           sync_q;
    rx_state_e            st_q;
    logic [TW-1:0]        tmr_q;
    logic [BW-1:0]        bit_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 rx_s;

    assign rx_s = sync_q[1];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q       <= 3'b111;
            st_q         <= RX_IDLE;
            tmr_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            byte_o       <= '0;
            byte_valid_o <= 1'b0;
            frame_err_o  <= 1'b0;
        end else begin
            sync_q       <= {sync_q[1:0], rx_i};
            byte_valid_o <= 1'b0;
            frame_err_o  <= 1'b0;
            case (st_q)
                RX_IDLE: begin
                    tmr_q <= '0;
                    if (sync_q[2] && !rx_s) st_q <= RX_START;
                end
                RX_START: begin
                    if (tmr_q == HALF_M1) begin
                        tmr_q <= '0;
                        bit_q <= '0;
                        st_q  <= rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        tmr_q <= tmr_q + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (tmr_q == FULL_M1) begin
                        tmr_q   <= '0;
                        shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
                        bit_q   <= bit_q + 1'b1;
                        if (bit_q == LAST_BIT) st_q <= RX_STOP;
                    end else begin
                        tmr_q <= tmr_q + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (tmr_q == FULL_M1) begin
                        tmr_q <= '0;
                        st_q  <= RX_IDLE;
                        if (rx_s) begin
                            byte_valid_o <= 1'b1;
                            byte_o       <= shift_q;
                        end else begin
                            frame_err_o <= 1'b1;
                        end
                    end else begin
                        tmr_q <= tmr_q + 1'b1;
                    end
                end
                default: st_q <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_prog_loader.sv
// Boot loader: assembles little-endian words from UART bytes and writes them to imem,
// holding the core in reset until the terminator word arrives.
module uart_prog_loader
    import ghazi_loader_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 347,
    parameter int          ADDR_W       = 10,
    parameter logic [31:0] TERM_WORD    = TERM_WORD_DEF
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              rx_i,
    output logic              ready_o,
    output logic              imem_req_o,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [31:0]       imem_wdata_o,
    input  logic              imem_gnt_i,
    output logic              core_rst_o,
    output logic              prog_done_o,
    output logic [ADDR_W:0]   word_cnt_o,
    output logic              err_o
);

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    logic                 byte_valid;
    logic                 frame_err;
    logic [DATA_BITS-1:0] rx_byte;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk_i        (wb_clk_i),
        .rst_i        (wb_rst_i),
        .rx_i         (rx_i),
        .byte_valid_o (byte_valid),
        .byte_o       (rx_byte),
        .frame_err_o  (frame_err)
    );

    loader_state_e    state_q;
    logic [1:0]       idx_q;
    logic [23:0]      asm_q;
    logic             ready_q, req_q, core_rst_q, done_q, err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]      wdata_q;
    logic [ADDR_W:0]  cnt_q;

    logic [31:0]      word_w;
    logic             granted;
    logic [ADDR_W:0]  cnt_nx;

    // A grant in the same cycle as a completing byte frees the write slot for the new word.
    always_comb begin
        word_w  = {rx_byte, asm_q};
        granted = (state_q == WRITE) && imem_gnt_i;
        cnt_nx  = cnt_q + {{ADDR_W{1'b0}}, granted};
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            asm_q      <= '0;
            ready_q    <= 1'b0;
            req_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            core_rst_q <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= LOAD;
                    ready_q <= 1'b1;
                end
                LOAD, WRITE: begin
                    if (frame_err) err_q <= 1'b1;
                    if (granted) begin
                        req_q   <= 1'b0;
                        addr_q  <= addr_q + 1'b1;
                        cnt_q   <= cnt_nx;
                        state_q <= LOAD;
                    end
                    if (byte_valid) begin
                        idx_q <= idx_q + 2'd1;
                        case (idx_q)
                            2'd0: asm_q[7:0]   <= rx_byte;
                            2'd1: asm_q[15:8]  <= rx_byte;
                            2'd2: asm_q[23:16] <= rx_byte;
                            default: begin
                                if ((state_q == WRITE) && !granted) begin
                                    err_q <= 1'b1;
                                end else if (word_w == TERM_WORD) begin
                                    state_q    <= DONE;
                                    ready_q    <= 1'b0;
                                    done_q     <= 1'b1;
                                    core_rst_q <= 1'b0;
                                end else if (cnt_nx == DEPTH) begin
                                    err_q <= 1'b1;
                                end else begin
                                    req_q   <= 1'b1;
                                    wdata_q <= word_w;
                                    state_q <= WRITE;
                                end
                            end
                        endcase
                    end
                end
                DONE: ;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ready_o      = ready_q;
    assign imem_req_o   = req_q;
    assign imem_we_o    = req_q;
    assign imem_addr_o  = addr_q;
    assign imem_wdata_o = wdata_q;
    assign core_rst_o   = core_rst_q;
    assign prog_done_o  = done_q;
    assign word_cnt_o   = cnt_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Bench for uart_prog_loader: two depths driven by one UART line against a byte-level image model.
module tb_uart_prog_loader;

    localparam int          CPB  = 16;
    localparam logic [31:0] TERM = 32'h0000_0FFF;

    logic clk = 1'b0, rst = 1'b1, rx = 1'b1, gnt = 1'b0;
    always #5 clk = ~clk;

    logic        rdy_b, req_b, we_b, crst_b, done_b, err_b;
    logic [9:0]  addr_b;
    logic [31:0] wd_b;
    logic [10:0] cnt_b;
    logic        rdy_s, req_s, we_s, crst_s, done_s, err_s;
    logic [1:0]  addr_s;
    logic [31:0] wd_s;
    logic [2:0]  cnt_s;

    uart_prog_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(10)) u_big (
        .wb_clk_i(clk), .wb_rst_i(rst), .rx_i(rx), .ready_o(rdy_b),
        .imem_req_o(req_b), .imem_we_o(we_b), .imem_addr_o(addr_b), .imem_wdata_o(wd_b),
        .imem_gnt_i(gnt), .core_rst_o(crst_b), .prog_done_o(done_b),
        .word_cnt_o(cnt_b), .err_o(err_b));

    uart_prog_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(2)) u_small (
        .wb_clk_i(clk), .wb_rst_i(rst), .rx_i(rx), .ready_o(rdy_s),
        .imem_req_o(req_s), .imem_we_o(we_s), .imem_addr_o(addr_s), .imem_wdata_o(wd_s),
        .imem_gnt_i(gnt), .core_rst_o(crst_s), .prog_done_o(done_s),
        .word_cnt_o(cnt_s), .err_o(err_s));

    logic        o_rdy[2], o_req[2], o_we[2], o_crst[2], o_done[2], o_err[2];
    logic [9:0]  o_addr[2];
    logic [31:0] o_wd[2];
    logic [10:0] o_cnt[2];
    assign o_rdy[0] = rdy_b;   assign o_rdy[1] = rdy_s;
    assign o_req[0] = req_b;   assign o_req[1] = req_s;
    assign o_we[0]  = we_b;    assign o_we[1]  = we_s;
    assign o_crst[0] = crst_b; assign o_crst[1] = crst_s;
    assign o_done[0] = done_b; assign o_done[1] = done_s;
    assign o_err[0] = err_b;   assign o_err[1] = err_s;
    assign o_addr[0] = addr_b; assign o_addr[1] = {8'd0, addr_s};
    assign o_wd[0]  = wd_b;    assign o_wd[1]  = wd_s;
    assign o_cnt[0] = cnt_b;   assign o_cnt[1] = {8'd0, cnt_s};

    int errors = 0, checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- image model ----------------
    int          m_idx;
    logic [31:0] m_word;
    bit          m_done;
    int          m_cnt[2];
    bit          m_err[2];
    logic [41:0] q0[$], q1[$];

    function automatic int depth(input int i);
        return (i == 0) ? 1024 : 4;
    endfunction

    task automatic model_reset();
        m_idx = 0; m_word = '0; m_done = 0;
        for (int i = 0; i < 2; i++) begin m_cnt[i] = 0; m_err[i] = 0; end
        q0.delete(); q1.delete();
    endtask

    task automatic model_byte(input logic [7:0] b, input bit ok);
        if (m_done) return;
        if (!ok) begin m_err[0] = 1; m_err[1] = 1; return; end
        m_word[8*m_idx +: 8] = b;
        m_idx = (m_idx + 1) % 4;
        if (m_idx != 0) return;
        if (m_word == TERM) begin m_done = 1; return; end
        for (int i = 0; i < 2; i++) begin
            if (m_cnt[i] == depth(i)) m_err[i] = 1;
            else begin
                if (i == 0) q0.push_back({10'(m_cnt[i]), m_word});
                else        q1.push_back({10'(m_cnt[i]), m_word});
                m_cnt[i]++;
            end
        end
    endtask

    // ---------------- grant driver ----------------
    int gmode = 0, stall = 0;
    always @(posedge clk) begin
        #1;
        if (rst) begin
            stall = 0;
            gnt = 1'b0;
        end else begin
            case (gmode)
                0: gnt = 1'b1;
                1: gnt = ($urandom_range(0, 2) != 0);
                default: begin
                    if (req_b && stall < 20) begin gnt = 1'b0; stall++; end
                    else begin gnt = req_b; if (!req_b) stall = 0; end
                end
            endcase
        end
    end

    // ---------------- per-cycle monitor ----------------
    logic        p_req[2], p_gnt;
    logic [9:0]  p_addr[2];
    logic [31:0] p_wd[2];
    int          run[2], run_max[2], wr_n[2];
    logic [9:0]  log_a[2][16];
    logic [31:0] log_d[2][16];

    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                p_req[i] = 0; run[i] = 0; run_max[i] = 0; wr_n[i] = 0;
            end
            p_gnt = 0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                logic [41:0] e;
                chk("we_eq_req", 64'(o_we[i]), 64'(o_req[i]));
                chk("core_rst_vs_done", 64'(o_crst[i]), 64'(!o_done[i]));
                if (p_req[i] && !p_gnt) begin
                    chk("hold_req", 64'(o_req[i]), 64'(1));
                    chk("hold_addr", 64'(o_addr[i]), 64'(p_addr[i]));
                    chk("hold_wdata", 64'(o_wd[i]), 64'(p_wd[i]));
                end
                if (o_req[i] && !gnt) begin
                    run[i]++;
                    if (run[i] > run_max[i]) run_max[i] = run[i];
                end else run[i] = 0;
                if (o_req[i] && gnt) begin
                    if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
                        checks++; errors++;
                        $display("FAIL unexpected_write inst=%0d addr=%0h data=%0h", i, o_addr[i], o_wd[i]);
                    end else begin
                        e = (i == 0) ? q0.pop_front() : q1.pop_front();
                        chk("wr_addr", 64'(o_addr[i]), 64'(e[41:32]));
                        chk("wr_data", 64'(o_wd[i]), 64'(e[31:0]));
                    end
                    if (wr_n[i] < 16) begin log_a[i][wr_n[i]] = o_addr[i]; log_d[i][wr_n[i]] = o_wd[i]; end
                    wr_n[i]++;
                end
                p_req[i] = o_req[i]; p_addr[i] = o_addr[i]; p_wd[i] = o_wd[i];
            end
            p_gnt = gnt;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_frame(input logic [7:0] b, input bit stop_ok);
        model_byte(b, stop_ok);
        rx = 1'b0; repeat (CPB) @(negedge clk);
        for (int k = 0; k < 8; k++) begin rx = b[k]; repeat (CPB) @(negedge clk); end
        rx = stop_ok; repeat (CPB) @(negedge clk);
        rx = 1'b1; repeat (3*CPB) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_frame(w[8*k +: 8], 1'b1);
    endtask

    task automatic check_reset(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk({tag, ":ready"}, 64'(o_rdy[i]), 64'(0));
            chk({tag, ":req"}, 64'(o_req[i]), 64'(0));
            chk({tag, ":addr"}, 64'(o_addr[i]), 64'(0));
            chk({tag, ":wdata"}, 64'(o_wd[i]), 64'(0));
            chk({tag, ":core_rst"}, 64'(o_crst[i]), 64'(1));
            chk({tag, ":done"}, 64'(o_done[i]), 64'(0));
            chk({tag, ":word_cnt"}, 64'(o_cnt[i]), 64'(0));
            chk({tag, ":err"}, 64'(o_err[i]), 64'(0));
        end
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        #1 check_reset(tag);
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic checkpoint(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk({tag, ":word_cnt"}, 64'(o_cnt[i]), 64'(m_cnt[i]));
            chk({tag, ":err"}, 64'(o_err[i]), 64'(m_err[i]));
            chk({tag, ":done"}, 64'(o_done[i]), 64'(m_done));
            chk({tag, ":ready"}, 64'(o_rdy[i]), 64'(!m_done));
            chk({tag, ":req_idle"}, 64'(o_req[i]), 64'(0));
        end
        chk({tag, ":pending_b"}, 64'(q0.size()), 64'(0));
        chk({tag, ":pending_s"}, 64'(q1.size()), 64'(0));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [31:0] w;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset("por");
        rst = 1'b0;
        #1 chk("idle_ready", 64'(rdy_b), 64'(0));
        @(negedge clk);
        chk("load_ready_b", 64'(rdy_b), 64'(1));
        chk("load_ready_s", 64'(rdy_s), 64'(1));
        chk("load_core_rst", 64'(crst_b), 64'(1));
        repeat (4*CPB) @(negedge clk);
        checkpoint("quiet");

        // basic image, grant tied high
        gmode = 0;
        send_word(32'h1234_5678);
        send_word(32'hDEAD_BEEF);
        send_word(TERM);
        checkpoint("basic");
        chk("basic_a0", 64'(log_a[0][0]), 64'(0));
        chk("basic_d0", 64'(log_d[0][0]), 64'h1234_5678);
        chk("basic_a1", 64'(log_a[0][1]), 64'(1));
        chk("basic_d1", 64'(log_d[0][1]), 64'hDEAD_BEEF);
        chk("basic_nwr", 64'(wr_n[0]), 64'(2));
        chk("basic_cnt", 64'(cnt_b), 64'(2));
        chk("basic_done", 64'(done_b), 64'(1));
        chk("basic_core_rst", 64'(crst_b), 64'(0));
        chk("basic_ready", 64'(rdy_b), 64'(0));
        send_word(32'h0000_0001);
        checkpoint("after_done");

        // grant withheld 20 cycles
        do_reset("rst_stall");
        gmode = 2;
        send_word(32'hA5A5_0001);
        checkpoint("stall0");
        chk("stall_len", 64'(run_max[0]), 64'(20));
        chk("stall_nwr", 64'(wr_n[0]), 64'(1));
        send_word(32'h0BAD_F00D);
        checkpoint("stall1");
        chk("stall_a1", 64'(log_a[0][1]), 64'(1));
        send_word(TERM);
        checkpoint("stall_term");

        // framing error between valid bytes
        do_reset("rst_ferr");
        gmode = 1;
        send_frame(8'h11, 1'b1);
        send_frame(8'h5A, 1'b0);
        send_frame(8'h22, 1'b1);
        send_frame(8'h33, 1'b1);
        send_frame(8'h44, 1'b1);
        checkpoint("ferr");
        chk("ferr_err", 64'(err_b), 64'(1));
        chk("ferr_d0", 64'(log_d[0][0]), 64'h4433_2211);
        send_word(32'hCAFE_0002);
        send_word(TERM);
        checkpoint("ferr_term");

        // overflow on the 4-deep instance
        do_reset("rst_ovf");
        gmode = 0;
        for (int n = 0; n < 5; n++) begin
            w = $urandom; if (w == TERM) w = w ^ 32'h1;
            send_word(w);
        end
        send_word(TERM);
        checkpoint("ovf");
        chk("ovf_cnt_s", 64'(cnt_s), 64'(4));
        chk("ovf_err_s", 64'(err_s), 64'(1));
        chk("ovf_done_s", 64'(done_s), 64'(1));
        chk("ovf_a3_s", 64'(log_a[1][3]), 64'(3));
        chk("ovf_cnt_b", 64'(cnt_b), 64'(5));
        chk("ovf_err_b", 64'(err_b), 64'(0));

        // reset in the middle of a word
        do_reset("rst_pre_mid");
        gmode = 1;
        send_frame(8'hAA, 1'b1);
        send_frame(8'hBB, 1'b1);
        do_reset("rst_mid");
        send_word(32'h1111_2222);
        send_word(32'h3333_4444);
        send_word(TERM);
        checkpoint("mid");
        chk("mid_a0", 64'(log_a[0][0]), 64'(0));
        chk("mid_d0", 64'(log_d[0][0]), 64'h1111_2222);

        // randomized images
        for (int r = 0; r < 4; r++) begin
            do_reset("rst_rand");
            gmode = $urandom_range(0, 1);
            for (int n = 0; n < int'($urandom_range(1, 5)); n++) begin
                if ($urandom_range(0, 5) == 0) send_frame(8'($urandom), 1'b0);
                w = $urandom; if (w == TERM) w = w ^ 32'h1;
                send_word(w);
                checkpoint("rand_word");
            end
            send_word(TERM);
            checkpoint("rand_term");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
- Boot-time program loader in the user project area: receives the program image serially on the mprj_io[5] UART line, assembles 32-bit instruction words and writes them into instruction memory over a req/gnt port.
- Holds the core in reset while loading and releases it when the terminator word arrives.
- Drives the ready indication on mprj_io[37], which the host/bench waits on before it starts transmitting.

Parameters:
- CLKS_PER_BIT, 347, wb_clk_i cycles per UART bit (40 MHz / 115200).
- ADDR_W, 10, imem word-address width; depth is 2**ADDR_W words.
- TERM_WORD, 32'h0000_0FFF, end-of-image marker word; it is never written to memory.

Ports:
- wb_clk_i  in  1  system clock.
- wb_rst_i  in  1  asynchronous active-high reset.
- rx_i  in  1  UART serial input, idle high, 8N1, LSB first.
- ready_o  out  1  loader waiting for or receiving an image (drives mprj_io[37]).
- imem_req_o  out  1  memory write request.
- imem_we_o  out  1  write enable; equals imem_req_o.
- imem_addr_o  out  ADDR_W  word address.
- imem_wdata_o  out  32  write data.
- imem_gnt_i  in  1  memory grant; the write completes in the cycle req && gnt.
- core_rst_o  out  1  core reset, active-high.
- prog_done_o  out  1  image loaded.
- word_cnt_o  out  ADDR_W+1  words written.
- err_o  out  1  sticky: framing, overrun or overflow error.

Behaviour:
- Reset values:
  - ready_o=0, imem_req_o=0, imem_addr_o=0, imem_wdata_o=0.
  - core_rst_o=1, prog_done_o=0, word_cnt_o=0, err_o=0.
  - FSM state is IDLE; byte index is 0.
- uart_rx:
  - rx_i passes through a 2-flop synchronizer.
  - Falling edge starts a frame; the start bit is re-checked at CLKS_PER_BIT/2 and treated as a glitch (back to idle) if high.
  - Data bits are sampled every CLKS_PER_BIT cycles from there.
  - Stop bit is sampled; if 0, the byte is dropped and a frame_err pulse is raised.
  - Otherwise it emits a 1-cycle byte_valid with the byte.
- FSM IDLE -> LOAD:
  - IDLE lasts one cycle after reset release.
  - LOAD is entered with ready_o=1.
- LOAD:
  - Each byte_valid shifts the byte into word bits [8*idx+7:8*idx] (little-endian); idx increments mod 4.
  - On the 4th byte: if word==TERM_WORD, go to DONE.
  - Otherwise latch wdata, assert imem_req_o and go to WRITE.
- WRITE:
  - imem_req_o, imem_addr_o and imem_wdata_o are held stable until gnt.
  - In the gnt cycle: addr+1, word_cnt+1, req drops next cycle, return to LOAD.
  - A byte_valid arriving in WRITE is accepted into the assembler normally.
  - If a 4th byte completes a new word while still in WRITE, err_o is set and that word is discarded (overrun).
- Overflow: a completed non-terminator word when word_cnt_o == 2**ADDR_W sets err_o, is not written, and the FSM stays in LOAD.
- DONE (terminal until reset):
  - ready_o=0, prog_done_o=1, core_rst_o=0 from the cycle after the terminator byte.
  - Further UART bytes are ignored.
- Errors: frame_err sets err_o; the loader continues.
- Latency: last data byte's byte_valid -> imem_req_o high in 1 cycle.
- Reset mid-load: all state returns to reset values immediately (async); a partial word is lost and memory contents are not cleared.
- Simultaneous gnt and byte_valid in the same cycle: both take effect.

Decomposition:
- Package ghazi_loader_pkg: loader_state_e enum {IDLE, LOAD, WRITE, DONE}; TERM_WORD default; UART frame constants (DATA_BITS=8).
- One sub-module: uart_rx (synchronizer, bit timer, 8N1 deserializer; outputs byte_valid, byte, frame_err).

Test Plan:
- Reset release, no traffic -> ready_o=1 after 1 cycle; core_rst_o=1; imem_req_o=0 throughout.
- Send bytes 78 56 34 12, EF BE AD DE, FF 0F 00 00 with gnt tied 1:
  - writes (0,32'h12345678) and (1,32'hDEADBEEF);
  - then prog_done_o=1, core_rst_o=0, ready_o=0, word_cnt_o=2.
- gnt held low 20 cycles on word 0:
  - req, addr=0 and wdata are stable all 20 cycles;
  - exactly one write occurs;
  - the next word lands at addr 1.
- Frame with stop bit 0 between valid bytes -> byte dropped, err_o=1, subsequent words assemble correctly.
- ADDR_W=2: send 5 data words then terminator -> 4 writes (addr 0..3), err_o=1 on the 5th word, DONE reached.
- Assert wb_rst_i after 2 bytes of a word -> outputs return to reset values; a fresh image then loads starting at addr 0.
